progmem_loader: RTL

- Writer side of the instruction memory. The core only ever reads program memory; this block fills it.
- Receives a framed byte stream and assembles little-endian 32-bit instruction words. Writes them to program memory at consecutive addresses from 0, and holds the core in reset for the duration of a load.
- Sits between the external byte source (debug/UART bridge) and the progmem write port. Sibling of program_counter at the top level.

---
 rtl/minimicro_pkg.sv | 32 +++
 rtl/progmem_loader.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/minimicro_pkg.sv
// Shared definitions for the minimicro core: instruction word layout,
// loader FSM state encoding and the default frame start marker.
package minimicro_pkg;

  // Instruction word and its field widths, shared by loader, decode and ALU.
  localparam int INSTR_WIDTH = 32;
  localparam int OPCODE_W    = 5;
  localparam int DEST_W      = 9;
  localparam int SRC1_W      = 9;
  localparam int SRC2_W      = 9;

  // Default frame start marker for the program loader.
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // Loader state encodings, kept as plain constants for older tooling.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_FINISH = 3'd5;

  typedef enum logic [2:0] {
    LS_IDLE   = ST_IDLE,
    LS_LEN_LO = ST_LEN_LO,
    LS_LEN_HI = ST_LEN_HI,
    LS_DATA   = ST_DATA,
    LS_CHECK  = ST_CHECK,
    LS_FINISH = ST_FINISH
  } loader_state_t;

endpackage

// File: rtl/progmem_loader.sv
// Program memory loader: parses a framed byte stream (SYNC, LEN_LO, LEN_HI,
// LEN little-endian words, XOR checksum), writes the words to progmem from
// address 0 and holds the core in reset while a load is in progress.
module progmem_loader
  import minimicro_pkg::*;
#(
  parameter int         ADDR_WIDTH = 8,
  parameter int         DEPTH      = 256,
  parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [INSTR_WIDTH-1:0] mem_wdata,
  output logic                   core_hold,
  output logic                   load_ok,
  output logic                   load_err
);

  // Length limit widened by one bit so LEN (16 bits) compares without overflow.
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  loader_state_t          state_q, state_d;
  logic [7:0]             len_lo_q, len_lo_d;
  logic [15:0]            len_q, len_d;
  logic [15:0]            word_cnt_q, word_cnt_d;
  logic [1:0]             byte_idx_q, byte_idx_d;
  logic [23:0]            word_buf_q, word_buf_d;
  logic [7:0]             checksum_q, checksum_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [INSTR_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                   core_hold_q, core_hold_d;
  logic                   load_ok_q, load_ok_d;
  logic                   load_err_q, load_err_d;
  logic                   accept;

  // Ready everywhere except the one-cycle FINISH state and while in reset.
  assign in_ready  = ~rst && (state_q != LS_FINISH);
  assign accept    = in_valid && in_ready;

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign core_hold = core_hold_q;
  assign load_ok   = load_ok_q;
  assign load_err  = load_err_q;

  // Next-state logic: frame parsing, word assembly, checksum and write strobe.
  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    byte_idx_d  = byte_idx_q;
    word_buf_d  = word_buf_q;
    checksum_d  = checksum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    core_hold_d = core_hold_q;
    load_ok_d   = load_ok_q;
    load_err_d  = load_err_q;

    case (state_q)
      LS_IDLE: begin
        // Non-sync bytes are silently dropped while waiting for a frame.
        if (accept && (in_data == SYNC_BYTE)) begin
          state_d     = LS_LEN_LO;
          core_hold_d = 1'b1;
          load_ok_d   = 1'b0;
          load_err_d  = 1'b0;
          checksum_d  = 8'h00;
          word_cnt_d  = 16'h0000;
          byte_idx_d  = 2'd0;
        end
      end

      LS_LEN_LO: begin
        if (accept) begin
          len_lo_d = in_data;
          state_d  = LS_LEN_HI;
        end
      end

      LS_LEN_HI: begin
        if (accept) begin
          len_d = {in_data, len_lo_q};
          // Rejecting oversize frames here guarantees the address never wraps.
          if ((len_d == 16'h0000) || ({1'b0, len_d} > DEPTH_W)) begin
            load_err_d = 1'b1;
            state_d    = LS_FINISH;
          end else begin
            state_d = LS_DATA;
          end
        end
      end

      LS_DATA: begin
        if (accept) begin
          checksum_d = checksum_q ^ in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: word_buf_d[7:0]   = in_data;
            2'd1: word_buf_d[15:8]  = in_data;
            2'd2: word_buf_d[23:16] = in_data;
            default: begin
              // Fourth byte completes the word; strobe it out next cycle.
              mem_we_d    = 1'b1;
              mem_wdata_d = {in_data, word_buf_q};
              mem_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
              word_cnt_d  = word_cnt_q + 16'd1;
              if (word_cnt_q == (len_q - 16'd1)) begin
                state_d = LS_CHECK;
              end
            end
          endcase
        end
      end

      LS_CHECK: begin
        // Words already written stay in progmem whatever the outcome.
        if (accept) begin
          if (in_data == checksum_q) begin
            load_ok_d = 1'b1;
          end else begin
            load_err_d = 1'b1;
          end
          state_d = LS_FINISH;
        end
      end

      LS_FINISH: begin
        core_hold_d = 1'b0;
        state_d     = LS_IDLE;
      end

      default: begin
        state_d = LS_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LS_IDLE;
      len_lo_q    <= 8'h00;
      len_q       <= 16'h0000;
      word_cnt_q  <= 16'h0000;
      byte_idx_q  <= 2'd0;
      word_buf_q  <= 24'h000000;
      checksum_q  <= 8'h00;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      core_hold_q <= 1'b0;
      load_ok_q   <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      byte_idx_q  <= byte_idx_d;
      word_buf_q  <= word_buf_d;
      checksum_q  <= checksum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      core_hold_q <= core_hold_d;
      load_ok_q   <= load_ok_d;
      load_err_q  <= load_err_d;
    end
  end

endmodule
